// File: rtl/display_pkg.sv
// Shared state encoding, channel indices and counter-width helpers
// for the BCM panel driver and its row shifter.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    DISPLAY = 2'd3
  } state_t;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // Never return a zero width, so single-entry dimensions still get a bit.
  function automatic int min_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int col_width(input int columns);
    return min_width(columns);
  endfunction

  function automatic int row_width(input int rows);
    return min_width(rows);
  endfunction

  function automatic int plane_width(input int cyclewidth);
    return min_width(cyclewidth);
  endfunction

  function automatic int disp_width(input int base, input int cyclewidth);
    return min_width((base << (cyclewidth - 1)) + 1);
  endfunction

  function automatic int shift_width(input int columns, input int latency);
    return min_width(2 * columns + latency + 1);
  endfunction

endpackage

// File: rtl/display_row_shifter.sv
// Shifts one bit plane of a row into the panel: walks col_addr, picks the
// plane bit out of each cpixel channel after the fetch latency, pulses sclk.
module display_row_shifter
  import display_pkg::*;
#(
  parameter int segments   = 1,
  parameter int bitwidth   = 8,
  parameter int cyclewidth = 8,
  parameter int columns    = 64,
  parameter int latency    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 clear,
  input  logic [plane_width(cyclewidth)-1:0]   plane,
  input  logic [bitwidth*3*segments-1:0]       cpixel,
  output logic [col_width(columns)-1:0]        col_addr,
  output logic [3*segments-1:0]                rgb,
  output logic                                 sclk,
  output logic                                 done
);

  localparam int CAW    = col_width(columns);
  localparam int KW     = shift_width(columns, latency);
  localparam int K_LAST = 2 * columns + latency;

  logic [KW-1:0]         k;
  logic                  busy;
  int                    kk;
  logic                  load_rgb;
  logic                  rise_sclk;
  logic [CAW-1:0]        col_next;
  logic [3*segments-1:0] plane_bits;
  logic                  unused_fields;

  // Field bits above cyclewidth carry no display information.
  assign unused_fields = ^cpixel;

  for (genvar g = 0; g < 3 * segments; g++) begin : g_chan
    logic [cyclewidth-1:0] field;
    assign field         = cpixel[g*bitwidth +: cyclewidth];
    assign plane_bits[g] = field[plane];
  end

  // Even k after the latency carries column data; the following odd k clocks it.
  always_comb begin
    kk        = int'(k);
    load_rgb  = busy && (kk >= latency) && (kk < K_LAST) && (((kk - latency) & 1) == 0);
    rise_sclk = busy && (kk >= latency + 1) && (kk <= K_LAST) &&
                (((kk - latency - 1) & 1) == 0);
    col_next  = (kk + 1 < 2 * columns) ? CAW'((kk + 1) / 2) : CAW'(columns - 1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      busy     <= 1'b0;
      k        <= '0;
      col_addr <= '0;
      rgb      <= '0;
      sclk     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      k        <= '0;
      col_addr <= '0;
      sclk     <= 1'b0;
      done     <= 1'b0;
    end else begin
      sclk <= rise_sclk;
      done <= busy && (kk == K_LAST - 1);
      if (load_rgb) rgb <= plane_bits;
      if (busy) begin
        col_addr <= col_next;
        if (kk == K_LAST) busy <= 1'b0;
        else              k    <= k + KW'(1);
      end
    end
  end

endmodule

// File: rtl/display_bcm_driver.sv
// HUB75 binary-code-modulation driver: per row and bit plane it shifts,
// latches, then enables the panel for base<<plane cycles.
module display_bcm_driver
  import display_pkg::*;
#(
  parameter int segments   = 1,
  parameter int bitwidth   = 8,
  parameter int cyclewidth = 8,
  parameter int columns    = 64,
  parameter int rows       = 16,
  parameter int latency    = 2,
  parameter int base       = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [bitwidth*3*segments-1:0] cpixel,
  output logic [col_width(columns)-1:0]  col_addr,
  output logic [row_width(rows)-1:0]     row_addr,
  output logic [3*segments-1:0]          rgb,
  output logic                           sclk,
  output logic                           latch,
  output logic                           oe_n,
  output logic                           frame_done
);

  localparam int RW = row_width(rows);
  localparam int PW = plane_width(cyclewidth);
  localparam int DW = disp_width(base, cyclewidth);
  localparam logic [PW-1:0] PLANE_LAST = PW'(cyclewidth - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(rows - 1);

  state_t        state;
  logic [RW-1:0] row;
  logic [PW-1:0] plane;
  logic [DW-1:0] disp_cnt;
  logic [DW-1:0] disp_load;
  logic          disp_end;
  logic          frame_end;
  logic          clear;
  logic          start;
  logic          shift_done;

  // The enable decision at a frame boundary is taken in the last DISPLAY cycle.
  always_comb begin
    disp_end  = (state == DISPLAY) && (disp_cnt == '0);
    frame_end = disp_end && (plane == PLANE_LAST) && (row == ROW_LAST);
    clear     = frame_end && !enable;
    start     = ((state == IDLE) && enable) || (disp_end && !clear);
    disp_load = DW'((base << plane) - 1);
  end

  display_row_shifter #(
    .segments   (segments),
    .bitwidth   (bitwidth),
    .cyclewidth (cyclewidth),
    .columns    (columns),
    .latency    (latency)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .clear    (clear),
    .plane    (plane),
    .cpixel   (cpixel),
    .col_addr (col_addr),
    .rgb      (rgb),
    .sclk     (sclk),
    .done     (shift_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      plane      <= '0;
      disp_cnt   <= '0;
      row_addr   <= '0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      latch      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= SHIFT;
            row   <= '0;
            plane <= '0;
          end
        end
        SHIFT: begin
          if (shift_done) begin
            state    <= LATCH;
            latch    <= 1'b1;
            row_addr <= row;
          end
        end
        LATCH: begin
          state    <= DISPLAY;
          oe_n     <= 1'b0;
          disp_cnt <= disp_load;
        end
        DISPLAY: begin
          if (disp_cnt == '0) begin
            oe_n <= 1'b1;
            if (plane != PLANE_LAST) begin
              plane <= plane + PW'(1);
              state <= SHIFT;
            end else begin
              plane <= '0;
              if (row == ROW_LAST) begin
                row        <= '0;
                frame_done <= 1'b1;
                if (enable) begin
                  state <= SHIFT;
                end else begin
                  state    <= IDLE;
                  row_addr <= '0;
                end
              end else begin
                row   <= row + RW'(1);
                state <= SHIFT;
              end
            end
          end else begin
            disp_cnt <= disp_cnt - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_bcm_driver.sv
// Directed bench for display_bcm_driver: a small single-segment panel for
// sequencing/timing and an 8-plane two-segment instance for the full gamut.
module tb_display_bcm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, enable2;
  int checks = 0;
  int fails  = 0;

  // Small panel: 4 columns, 2 rows, 2 planes
  logic [23:0] cpixel;
  logic [1:0]  col_addr;
  logic [0:0]  row_addr;
  logic [2:0]  rgb;
  logic        sclk, latch, oe_n, frame_done;
  logic [1:0]  d1, d2;

  // R = column, G = ~column with upper bits set, B low bits clear with upper bits set
  assign cpixel = {8'hFC, 6'h3F, ~d2, 6'h00, d2};
  always @(posedge clk) begin
    d1 <= col_addr;
    d2 <= d1;
  end

  display_bcm_driver #(
    .segments(1), .bitwidth(8), .cyclewidth(2), .columns(4),
    .rows(2), .latency(2), .base(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cpixel(cpixel),
    .col_addr(col_addr), .row_addr(row_addr), .rgb(rgb), .sclk(sclk),
    .latch(latch), .oe_n(oe_n), .frame_done(frame_done)
  );

  // Two segments, 8 planes, every field full except segment 1 blue
  logic [47:0] cpixel2;
  logic [1:0]  col_addr2;
  logic [0:0]  row_addr2;
  logic [5:0]  rgb2;
  logic        sclk2, latch2, oe_n2, frame_done2;

  assign cpixel2 = 48'h00FF_FFFF_FFFF;

  display_bcm_driver #(
    .segments(2), .bitwidth(8), .cyclewidth(8), .columns(4),
    .rows(2), .latency(2), .base(1)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .cpixel(cpixel2),
    .col_addr(col_addr2), .row_addr(row_addr2), .rgb(rgb2), .sclk(sclk2),
    .latch(latch2), .oe_n(oe_n2), .frame_done(frame_done2)
  );

  logic       sclk_log  [200];
  logic [2:0] rgb_log   [200];
  logic       latch_log [200];
  logic [0:0] row_log   [200];
  logic       oe_log    [200];
  logic       fd_log    [200];
  logic [1:0] col_log   [200];

  int         exp_sclk_n [16] = '{4, 6, 8, 10, 17, 19, 21, 23, 31, 33, 35, 37, 44, 46, 48, 50};
  logic [2:0] exp_rgb    [16] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b010, 3'b001, 3'b001,
                                  3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b010, 3'b001, 3'b001};
  int         exp_latch_n [4] = '{11, 24, 38, 51};
  logic [0:0] exp_latch_row [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  int         exp_oe_n [6] = '{12, 25, 26, 39, 52, 53};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int n);
    sclk_log[n]  = sclk;
    rgb_log[n]   = rgb;
    latch_log[n] = latch;
    row_log[n]   = row_addr;
    oe_log[n]    = oe_n;
    fd_log[n]    = frame_done;
    col_log[n]   = col_addr;
  endtask

  initial begin
    int cnt, bad, cnt_oe, cnt_latch, cnt_fd;
    rst = 1'b1; enable = 1'b0; enable2 = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset col_addr",   64'(col_addr),   64'd0);
    chk("reset row_addr",   64'(row_addr),   64'd0);
    chk("reset rgb",        64'(rgb),        64'd0);
    chk("reset sclk",       64'(sclk),       64'd0);
    chk("reset latch",      64'(latch),      64'd0);
    chk("reset oe_n",       64'(oe_n),       64'd1);
    chk("reset frame_done", 64'(frame_done), 64'd0);
    chk("reset dut2 oe_n",  64'(oe_n2),      64'd1);
    chk("reset dut2 col",   64'(col_addr2),  64'd0);

    // Phase 1: continuous frames, then drop enable in row 1 of the third frame
    rst = 1'b0; enable = 1'b1;
    for (int n = 0; n < 176; n++) begin
      @(negedge clk);
      sample(n);
      if (n == 140) enable = 1'b0;
    end

    chk("col_addr k0",  64'(col_log[0]),  64'd0);
    chk("col_addr k3",  64'(col_log[3]),  64'd1);
    chk("col_addr k5",  64'(col_log[5]),  64'd2);
    chk("col_addr k10", 64'(col_log[10]), 64'd3);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sclk_high[%0d]", i), 64'(sclk_log[exp_sclk_n[i]]), 64'd1);
      chk($sformatf("rgb_at_sclk[%0d]", i), 64'(rgb_log[exp_sclk_n[i]]), 64'(exp_rgb[i]));
    end
    cnt = 0; cnt_oe = 0; cnt_latch = 0;
    for (int n = 0; n < 54; n++) begin
      if (sclk_log[n] === 1'b1)  cnt++;
      if (oe_log[n] === 1'b0)    cnt_oe++;
      if (latch_log[n] === 1'b1) cnt_latch++;
    end
    chk("sclk count frame0",  64'(cnt),       64'd16);
    chk("oe low count frame0", 64'(cnt_oe),   64'd6);
    chk("latch count frame0", 64'(cnt_latch), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("latch_at[%0d]", i), 64'(latch_log[exp_latch_n[i]]), 64'd1);
      chk($sformatf("row_at_latch[%0d]", i), 64'(row_log[exp_latch_n[i]]), 64'(exp_latch_row[i]));
      chk($sformatf("oe_during_latch[%0d]", i), 64'(oe_log[exp_latch_n[i]]), 64'd1);
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("oe_low_at[%0d]", i), 64'(oe_log[exp_oe_n[i]]), 64'd0);
    chk("oe high after plane1", 64'(oe_log[27]), 64'd1);

    cnt_fd = 0;
    for (int n = 0; n < 120; n++) if (fd_log[n] === 1'b1) cnt_fd++;
    chk("frame_done count 2 frames", 64'(cnt_fd), 64'd2);
    chk("frame_done at 54",  64'(fd_log[54]),  64'd1);
    chk("frame_done at 108", 64'(fd_log[108]), 64'd1);
    chk("no idle gap sclk",  64'(sclk_log[58]), 64'd1);
    chk("frame2 row0 latch", 64'(latch_log[65]), 64'd1);
    chk("frame2 row0 addr",  64'(row_log[65]),   64'd0);

    cnt_fd = 0;
    for (int n = 109; n < 176; n++) if (fd_log[n] === 1'b1) cnt_fd++;
    chk("frame_done count after drop", 64'(cnt_fd), 64'd1);
    chk("frame_done at 162", 64'(fd_log[162]), 64'd1);
    bad = 0;
    for (int n = 162; n < 176; n++)
      if (col_log[n] !== 2'd0 || row_log[n] !== 1'b0 || rgb_log[n] !== 3'd0 ||
          sclk_log[n] !== 1'b0 || latch_log[n] !== 1'b0 || oe_log[n] !== 1'b1) bad++;
    chk("idle outputs at reset values", 64'(bad), 64'd0);

    // Phase 2: reassert, then reset in the row 1 plane 1 display
    enable = 1'b1;
    for (int m = 0; m < 53; m++) begin
      @(negedge clk);
      sample(m);
    end
    rst = 1'b1;
    chk("restart sclk m3",   64'(sclk_log[3]),  64'd0);
    chk("restart sclk m4",   64'(sclk_log[4]),  64'd1);
    chk("restart rgb m4",    64'(rgb_log[4]),   64'd2);
    chk("restart latch m11", 64'(latch_log[11]), 64'd1);
    chk("pre-reset oe_n",    64'(oe_log[52]),   64'd0);
    chk("pre-reset rgb",     64'(rgb_log[52]),  64'd1);
    chk("pre-reset row",     64'(row_log[52]),  64'd1);
    @(negedge clk);
    chk("post-reset oe_n",     64'(oe_n),     64'd1);
    chk("post-reset sclk",     64'(sclk),     64'd0);
    chk("post-reset latch",    64'(latch),    64'd0);
    chk("post-reset rgb",      64'(rgb),      64'd0);
    chk("post-reset row_addr", 64'(row_addr), 64'd0);
    chk("post-reset col_addr", 64'(col_addr), 64'd0);

    // Phase 3: two segments, eight planes, one row
    rst = 1'b0; enable = 1'b0; enable2 = 1'b1;
    cnt = 0; bad = 0; cnt_oe = 0; cnt_latch = 0; cnt_fd = 0;
    for (int m = 0; m < 351; m++) begin
      @(negedge clk);
      if (sclk2 === 1'b1) begin
        cnt++;
        if (rgb2 !== 6'b011111) bad++;
      end
      if (oe_n2 === 1'b0) cnt_oe++;
      if (latch2 === 1'b1) begin
        cnt_latch++;
        if (row_addr2 !== 1'b0) bad++;
      end
      if (frame_done2 === 1'b1) cnt_fd++;
    end
    chk("gamut sclk count",     64'(cnt),       64'd32);
    chk("gamut rgb mismatches", 64'(bad),       64'd0);
    chk("gamut display cycles", 64'(cnt_oe),    64'd255);
    chk("gamut latch count",    64'(cnt_latch), 64'd8);
    chk("gamut no frame_done",  64'(cnt_fd),    64'd0);
    @(negedge clk);
    chk("gamut row1 shifting oe_n", 64'(oe_n2), 64'd1);
    chk("dut1 stays idle oe_n",     64'(oe_n),  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/display_bcm_driver.md
# display_bcm_driver

Drives a HUB75-style LED panel from gamma-corrected pixel data using binary-code modulation (BCM). It sits directly downstream of the display colour encoder:
- It issues column addresses to the pixel source.
- It receives the corrected `cpixel` word a fixed number of cycles later.
- For each row and bit plane, it shifts one bit per channel into the panel, latches, and enables output for a duration weighted by the bit's significance.

## Interface
- `segments`, 1: parallel RGB output groups (panel halves).
- `bitwidth`, 8: per-channel field stride in `cpixel`.
- `cyclewidth`, 8: significant bits per channel; also the number of bit planes; ≤ `bitwidth`.
- `columns`, 64: pixels shifted per row.
- `rows`, 16: row addresses per segment.
- `latency`, 2: cycles from `col_addr` to the matching `cpixel`.
- `base`, 1: display cycles for bit plane 0.

Ports (clock and reset first):
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; sampled only at frame boundaries.
- `cpixel`  in  `bitwidth*3*segments`  corrected pixel. Channel g = segment*3 + {R=0, G=1, B=2} occupies bits [g*bitwidth +: cyclewidth].
- `col_addr`  out  clog2(`columns`)  column being fetched.
- `row_addr`  out  clog2(`rows`)  panel row select.
- `rgb`  out  3*`segments`  shift data; bit g is channel g.
- `sclk`  out  1  panel shift clock.
- `latch`  out  1  panel latch strobe.
- `oe_n`  out  1  panel output enable, active low.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE:
  - Outputs are held at their reset values.
  - If `enable`=1, go to SHIFT with row=0 and plane b=0.
- SHIFT uses counter k = 0 .. 2*`columns`+`latency`.
  - `col_addr` = k>>1 while k < 2*`columns`; it holds `columns`-1 afterwards.
  - At the end of cycle k = 2c+`latency`: `rgb`[g] is registered from `cpixel` channel g, bit b.
  - At the end of cycle k = 2c+`latency`+1: `sclk` is registered high, for one cycle.
  - After k = 2*`columns`+`latency`, go to LATCH.
- LATCH lasts 1 cycle:
  - `latch`=1.
  - `row_addr` updates to the current row in this cycle.
  - `oe_n`=1.
- DISPLAY:
  - `oe_n`=0 for exactly `base`<<b cycles.
  - Then, if b < `cyclewidth`-1: increment b and go to SHIFT.
  - Otherwise: reset b to 0 and increment the row.
    - If the row wraps from `rows`-1 to 0, pulse `frame_done` in the first cycle after DISPLAY. Then go to SHIFT if `enable`=1, else IDLE.
    - If it does not wrap, go to SHIFT.
- `oe_n` is 1 in every state except DISPLAY. `row_addr` never changes while `oe_n`=0.
- `cpixel` bits above `cyclewidth` in each field are ignored.
- The display counter is wide enough for `base`<<(`cyclewidth`-1). Counters never wrap within a phase.

## Timing
- Reset values: `col_addr`=0, `row_addr`=0, `rgb`=0, `sclk`=0, `latch`=0, `oe_n`=1, `frame_done`=0; state IDLE.
- Cycle counts:
  - SHIFT: 2*`columns`+`latency`+1 cycles.
  - LATCH: 1 cycle.
  - DISPLAY: `base`<<b cycles.
  - One frame: `rows`*(`cyclewidth`*(2*`columns`+`latency`+2) + `base`*(2^`cyclewidth`-1)).
- `rgb` is stable for at least one cycle before each `sclk` rising edge, and for one cycle after it.
- `rst` during any state: return to IDLE on the next edge with reset values. No partial latch or display completes.
- `enable` deasserted mid-frame: the current frame completes, including `frame_done`, then the block goes to IDLE.
- `enable` reasserted in the same cycle as `frame_done`: continue to SHIFT with no IDLE cycle.

## Structure
- Shared package `display_pkg`:
  - State enum (IDLE/SHIFT/LATCH/DISPLAY).
  - Helper functions for counter widths (clog2 of `columns`, `rows`, and `base`<<(`cyclewidth`-1)).
  - Channel index constants R=0, G=1, B=2.
- One sub-module, `display_row_shifter`, owns:
  - the SHIFT counter, `col_addr`, bit-plane selection from `cpixel`, `rgb`, and `sclk` generation;
  - a `start` input and a `done` pulse.
- The top-level FSM owns LATCH/DISPLAY, the row and plane counters, `oe_n`, `latch`, and `frame_done`.

## Test plan
Common config unless noted: `columns`=4, `rows`=2, `cyclewidth`=2, `latency`=2, `base`=1, `segments`=1.
- **Column fetch.** Model `cpixel` as a 2-cycle-delayed function of `col_addr`, with R field = `col_addr`. Release `rst`, `enable`=1. Plane 0 `rgb`[0] at the 4 `sclk` rises is 0,1,0,1. Plane 1 gives 0,0,1,1. SHIFT lasts 11 cycles.
- **BCM weighting.** Plane 0 gives `oe_n` low for 1 cycle; plane 1 gives 2 cycles. `latch` is high exactly 1 cycle before each DISPLAY. `row_addr` is 0 for row 0 latches and 1 for row 1 latches.
- **Frame timing.** `enable` held high. `frame_done` pulses every 54 cycles. `row_addr` returns to 0. There is no IDLE gap.
- **Enable drop.** Deassert `enable` mid-row-1. The frame finishes, `frame_done` pulses once, and outputs then stay at reset values. Reassert: SHIFT starts on the next cycle.
- **Mid-operation reset.** Assert `rst` for 1 cycle during DISPLAY of plane 1. Next cycle: `oe_n`=1, `sclk`=0, `latch`=0, `rgb`=0, `row_addr`=0.
- **Multi-segment, full gamut.** `segments`=2, `cyclewidth`=8, `base`=1, `cpixel` fields = 0xFF except segment 1 B = 0x00. All `rgb` bits are 1 on every plane except bit 5, which is 0. Total DISPLAY cycles per row = 255.
